mega_regfile_wb: RTL and testbench

MEGA_REGFILE_WB -- requirements
Module: mega_regfile_wb

---
 rtl/mega_regfile_wb.sv | 174 +++++++++++++++++
 tb/tb_mega_regfile_wb.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mega_regfile_wb.sv
// mega_regfile_wb: 32 x 8-bit register file with a status register.
// After reset an init sequencer clears r0..r31 one byte per cycle, then
// the block accepts 8-bit and 16-bit writes. Reads are combinational,
// with optional same-cycle forwarding of the write data.
module mega_regfile_wb #(
  parameter int unsigned BYPASS     = 1,
  parameter logic [7:0]  SREG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic [4:0]  rda,
  input  logic [4:0]  rra,
  output logic [15:0] rd,
  output logic [15:0] rr,
  input  logic        wr_en,
  input  logic        wr_word,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        sreg_we,
  input  logic [7:0]  sreg_nxt,
  input  logic        io_sreg_we,
  input  logic [7:0]  io_sreg_data,
  output logic [7:0]  sreg,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] z
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Sequencer state.
  state_e     r_state;
  state_e     w_state_nxt;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  logic       w_ready;

  // Register array and status register.
  logic [7:0] r_mem [32];
  logic [7:0] r_sreg;

  // The two byte write lanes shared by init clearing and normal writes.
  logic       w_we_lo;
  logic       w_we_hi;
  logic [4:0] w_addr_lo;
  logic [4:0] w_addr_hi;
  logic [7:0] w_data_lo;
  logic [7:0] w_data_hi;

  // Read view of every byte after forwarding and init masking.
  logic [7:0] w_view [32];

  // State and init counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: walk cnt through r0..r31, enter RUN after r31.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    unique case (r_state)
      INIT: begin
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  assign ready = w_ready;

  // Write lane selection: init clears r[cnt]; RUN decodes byte/word writes.
  always_comb begin
    w_we_lo   = 1'b0;
    w_we_hi   = 1'b0;
    w_addr_lo = wr_addr;
    w_addr_hi = wr_addr | 5'd1;
    w_data_lo = wr_data[7:0];
    w_data_hi = wr_data[15:8];
    if (r_state == INIT) begin
      w_we_lo   = 1'b1;
      w_addr_lo = r_cnt;
      w_data_lo = 8'h00;
    end else if (wr_en) begin
      w_we_lo = 1'b1;
      if (wr_word) begin
        // Word writes always target an aligned pair; wr_addr[0] is ignored.
        w_addr_lo = wr_addr & 5'h1E;
        w_we_hi   = 1'b1;
      end
    end
  end

  // Register array write port.
  // NOTE: the array has no reset so it can map onto distributed/block RAM;
  // its contents are defined by the init sequence instead.
  always_ff @(posedge clk) begin
    if (w_we_lo) begin
      r_mem[w_addr_lo] <= w_data_lo;
    end
    if (w_we_hi) begin
      r_mem[w_addr_hi] <= w_data_hi;
    end
  end

  // Status register: I/O bus write has priority over the ALU flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= SREG_RESET;
    end else if (r_state == RUN) begin
      if (io_sreg_we) begin
        r_sreg <= io_sreg_data;
      end else if (sreg_we) begin
        r_sreg <= sreg_nxt;
      end
    end
  end

  // SREG is never forwarded; the ALU sees new flags the cycle after.
  assign sreg = r_sreg;

  // Per-byte read view: forward bytes being written this cycle when
  // BYPASS is set, and present zeros while the array is still being cleared.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_view[i] = r_mem[i];
      if (BYPASS != 0) begin
        if (w_we_lo && (w_addr_lo == 5'(i))) begin
          w_view[i] = w_data_lo;
        end
        if (w_we_hi && (w_addr_hi == 5'(i))) begin
          w_view[i] = w_data_hi;
        end
      end
      if (r_state == INIT) begin
        w_view[i] = 8'h00;
      end
    end
  end

  // Operand pairs: an odd address yields the same byte in both halves
  // because addr|1 equals addr, so nothing wraps past r31.
  assign rd = {w_view[rda | 5'd1], w_view[rda]};
  assign rr = {w_view[rra | 5'd1], w_view[rra]};

  // Pointer register pairs.
  assign x = {w_view[27], w_view[26]};
  assign y = {w_view[29], w_view[28]};
  assign z = {w_view[31], w_view[30]};

endmodule

// File: tb/tb_mega_regfile_wb.sv
// Bench for mega_regfile_wb: two instances (forwarding on / off, distinct
// SREG reset values) share one stimulus stream and are compared against
// a byte-array reference model.
module tb_mega_regfile_wb;

  localparam logic [7:0] SR_A = 8'h00;
  localparam logic [7:0] SR_B = 8'h5A;

  logic        clk;
  logic        rst;
  logic [4:0]  rda;
  logic [4:0]  rra;
  logic        wr_en;
  logic        wr_word;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        sreg_we;
  logic [7:0]  sreg_nxt;
  logic        io_sreg_we;
  logic [7:0]  io_sreg_data;

  logic        ready_a, ready_b;
  logic [15:0] rd_a, rr_a, x_a, y_a, z_a;
  logic [15:0] rd_b, rr_b, x_b, y_b, z_b;
  logic [7:0]  sreg_a, sreg_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] m_mem [32];
  logic [7:0] m_sreg_a;
  logic [7:0] m_sreg_b;

  mega_regfile_wb #(.BYPASS(1), .SREG_RESET(SR_A)) dut (
    .clk(clk), .rst(rst), .ready(ready_a), .rda(rda), .rra(rra),
    .rd(rd_a), .rr(rr_a), .wr_en(wr_en), .wr_word(wr_word),
    .wr_addr(wr_addr), .wr_data(wr_data), .sreg_we(sreg_we),
    .sreg_nxt(sreg_nxt), .io_sreg_we(io_sreg_we),
    .io_sreg_data(io_sreg_data), .sreg(sreg_a), .x(x_a), .y(y_a), .z(z_a)
  );

  mega_regfile_wb #(.BYPASS(0), .SREG_RESET(SR_B)) dut_nb (
    .clk(clk), .rst(rst), .ready(ready_b), .rda(rda), .rra(rra),
    .rd(rd_b), .rr(rr_b), .wr_en(wr_en), .wr_word(wr_word),
    .wr_addr(wr_addr), .wr_data(wr_data), .sreg_we(sreg_we),
    .sreg_nxt(sreg_nxt), .io_sreg_we(io_sreg_we),
    .io_sreg_data(io_sreg_data), .sreg(sreg_b), .x(x_b), .y(y_b), .z(z_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model view of one byte; byp selects whether a pending write is visible.
  function automatic logic [7:0] m_byte(input int a, input bit byp);
    if (byp && wr_en) begin
      if (wr_word) begin
        if (a == int'(wr_addr & 5'h1E)) return wr_data[7:0];
        if (a == int'(wr_addr | 5'h01)) return wr_data[15:8];
      end else if (a == int'(wr_addr)) begin
        return wr_data[7:0];
      end
    end
    return m_mem[a];
  endfunction

  function automatic logic [15:0] m_pair(input int a, input bit byp);
    return {m_byte(a | 1, byp), m_byte(a, byp)};
  endfunction

  // Apply the current inputs to the model as a clock edge would.
  task automatic m_commit();
    if (wr_en) begin
      if (wr_word) begin
        m_mem[wr_addr & 5'h1E] = wr_data[7:0];
        m_mem[wr_addr | 5'h01] = wr_data[15:8];
      end else begin
        m_mem[wr_addr] = wr_data[7:0];
      end
    end
    if (io_sreg_we) begin
      m_sreg_a = io_sreg_data;
      m_sreg_b = io_sreg_data;
    end else if (sreg_we) begin
      m_sreg_a = sreg_nxt;
      m_sreg_b = sreg_nxt;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_sreg_a = SR_A;
    m_sreg_b = SR_B;
  endtask

  task automatic idle_inputs();
    wr_en        = 1'b0;
    wr_word      = 1'b0;
    wr_addr      = 5'd0;
    wr_data      = 16'h0000;
    sreg_we      = 1'b0;
    sreg_nxt     = 8'h00;
    io_sreg_we   = 1'b0;
    io_sreg_data = 8'h00;
  endtask

  task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_word = 1'b0; wr_addr = a; wr_data = {8'h00, d};
  endtask

  task automatic write_word(input logic [4:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_word = 1'b1; wr_addr = a; wr_data = d;
  endtask

  // One rising edge, with the model following along.
  task automatic step();
    @(posedge clk);
    m_commit();
  endtask

  // Count 32 edges after reset release, checking ready and masked reads.
  task automatic run_init(input string tag);
    logic exp_rdy;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      exp_rdy = (k == 32);
      n_tests++;
      if (ready_a !== exp_rdy || ready_b !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s ready edge %0d: got %b/%b expected %b", tag, k, ready_a, ready_b, exp_rdy);
      end
      if (k < 32) begin
        rda = 5'($urandom);
        rra = 5'($urandom);
        #1;
        n_tests++;
        if ({rd_a, rr_a, x_a, y_a, z_a, rd_b, rr_b, x_b, y_b, z_b} !== 160'd0) begin
          n_fail++;
          $display("FAIL %s init reads edge %0d: got %h %h %h %h %h expected 0", tag, k, rd_a, rr_a, x_a, y_a, z_a);
        end
        n_tests++;
        if (sreg_a !== SR_A || sreg_b !== SR_B) begin
          n_fail++;
          $display("FAIL %s init sreg edge %0d: got %h/%h expected %h/%h", tag, k, sreg_a, sreg_b, SR_A, SR_B);
        end
      end
    end
    idle_inputs();
    m_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    rda = 5'd0;
    rra = 5'd1;
    #1;
    n_tests++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready: got %b/%b expected 0", ready_a, ready_b);
    end
    n_tests++;
    if (sreg_a !== SR_A || sreg_b !== SR_B) begin
      n_fail++;
      $display("FAIL reset sreg: got %h/%h expected %h/%h", sreg_a, sreg_b, SR_A, SR_B);
    end
    // Writes and flag updates attempted during init must be ignored.
    write_byte(5'd0, 8'hFF);
    sreg_we  = 1'b1;
    sreg_nxt = 8'h3C;
    @(negedge clk);
    rst = 1'b0;
    run_init("reset");
    for (int a = 0; a < 32; a += 2) begin
      @(negedge clk);
      rda = 5'(a);
      rra = 5'(a + 1);
      #1;
      n_tests++;
      if ({rd_a, rr_a, rd_b, rr_b} !== 64'd0) begin
        n_fail++;
        $display("FAIL cleared r%0d/r%0d: got %h %h %h %h expected 0", a, a + 1, rd_a, rr_a, rd_b, rr_b);
      end
    end
  endtask

  task automatic test_directed();
    @(negedge clk);
    write_byte(5'd5, 8'hA7);
    step();
    @(negedge clk);
    write_word(5'd25, 16'h1234);
    rda = 5'd24;
    #1;
    n_tests++;
    if (rd_a !== 16'h1234 || rd_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL word write same cycle rd: got %h/%h expected 1234/0000", rd_a, rd_b);
    end
    step();
    @(negedge clk);
    idle_inputs();
    rda = 5'd24;
    rra = 5'd5;
    #1;
    n_tests++;
    if (rd_a !== 16'h1234 || rd_b !== 16'h1234) begin
      n_fail++;
      $display("FAIL word write rd(24): got %h/%h expected 1234", rd_a, rd_b);
    end
    n_tests++;
    if (rr_a !== 16'hA7A7 || rr_b !== 16'hA7A7) begin
      n_fail++;
      $display("FAIL odd rr(5): got %h/%h expected a7a7", rr_a, rr_b);
    end
    n_tests++;
    if (x_a !== 16'h0000 || x_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL x unchanged: got %h/%h expected 0000", x_a, x_b);
    end
    rra = 5'd4;
    #1;
    n_tests++;
    if (rr_a !== 16'hA700 || rr_b !== 16'hA700) begin
      n_fail++;
      $display("FAIL rr(4): got %h/%h expected a700", rr_a, rr_b);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    write_byte(5'd3, 8'h11);
    step();
    @(negedge clk);
    write_byte(5'd3, 8'h5C);
    rra = 5'd3;
    rda = 5'd2;
    #1;
    n_tests++;
    if (rr_a !== 16'h5C5C || rr_b !== 16'h1111) begin
      n_fail++;
      $display("FAIL bypass rr(3) same cycle: got %h/%h expected 5c5c/1111", rr_a, rr_b);
    end
    n_tests++;
    if (rd_a !== 16'h5C00 || rd_b !== 16'h1100) begin
      n_fail++;
      $display("FAIL bypass rd(2) same cycle: got %h/%h expected 5c00/1100", rd_a, rd_b);
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (rr_a[7:0] !== 8'h5C || rr_b[7:0] !== 8'h5C) begin
      n_fail++;
      $display("FAIL bypass rr(3) next cycle: got %h/%h expected 5c", rr_a[7:0], rr_b[7:0]);
    end
    // Odd word address: bit 0 ignored, lands on r26/r27 (x).
    @(negedge clk);
    write_word(5'd27, 16'hBEEF);
    #1;
    n_tests++;
    if (x_a !== 16'hBEEF || x_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL bypass x same cycle: got %h/%h expected beef/0000", x_a, x_b);
    end
    step();
    @(negedge clk);
    write_byte(5'd31, 8'h77);
    #1;
    n_tests++;
    if (x_a !== 16'hBEEF || x_b !== 16'hBEEF || z_a[15:8] !== 8'h77 || z_b[15:8] !== 8'h00) begin
      n_fail++;
      $display("FAIL x next / z same cycle: got %h/%h %h/%h expected beef/beef 77xx/00xx", x_a, x_b, z_a, z_b);
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (z_a[15:8] !== 8'h77 || z_b[15:8] !== 8'h77) begin
      n_fail++;
      $display("FAIL z next cycle: got %h/%h expected 77", z_a[15:8], z_b[15:8]);
    end
  endtask

  task automatic test_sreg();
    @(negedge clk);
    sreg_we = 1'b1; sreg_nxt = 8'h03;
    io_sreg_we = 1'b1; io_sreg_data = 8'h80;
    #1;
    n_tests++;
    if (sreg_a !== SR_A || sreg_b !== SR_B) begin
      n_fail++;
      $display("FAIL sreg not bypassed: got %h/%h expected %h/%h", sreg_a, sreg_b, SR_A, SR_B);
    end
    step();
    @(negedge clk);
    io_sreg_we = 1'b0;
    sreg_we = 1'b1; sreg_nxt = 8'h02;
    write_byte(5'd7, 8'h42);
    #1;
    n_tests++;
    if (sreg_a !== 8'h80 || sreg_b !== 8'h80) begin
      n_fail++;
      $display("FAIL sreg io priority: got %h/%h expected 80", sreg_a, sreg_b);
    end
    step();
    @(negedge clk);
    idle_inputs();
    rda = 5'd6;
    #1;
    n_tests++;
    if (sreg_a !== 8'h02 || sreg_b !== 8'h02) begin
      n_fail++;
      $display("FAIL sreg alu write: got %h/%h expected 02", sreg_a, sreg_b);
    end
    n_tests++;
    if (rd_a !== 16'h4200 || rd_b !== 16'h4200) begin
      n_fail++;
      $display("FAIL reg write with sreg write: got %h/%h expected 4200", rd_a, rd_b);
    end
  endtask

  task automatic test_random();
    string       nm [12];
    logic [15:0] got [12];
    logic [15:0] exp [12];
    nm = '{"rd_a", "rr_a", "x_a", "y_a", "z_a", "rd_b", "rr_b", "x_b", "y_b", "z_b", "sreg_a", "sreg_b"};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr_en        = ($urandom_range(0, 2) != 0);
      wr_word      = 1'($urandom);
      wr_addr      = 5'($urandom);
      wr_data      = 16'($urandom);
      sreg_we      = ($urandom_range(0, 2) == 0);
      sreg_nxt     = 8'($urandom);
      io_sreg_we   = ($urandom_range(0, 3) == 0);
      io_sreg_data = 8'($urandom);
      rda          = 5'($urandom);
      rra          = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      #1;
      got = '{rd_a, rr_a, x_a, y_a, z_a, rd_b, rr_b, x_b, y_b, z_b, {8'h00, sreg_a}, {8'h00, sreg_b}};
      exp = '{m_pair(int'(rda), 1), m_pair(int'(rra), 1), m_pair(26, 1), m_pair(28, 1), m_pair(30, 1),
              m_pair(int'(rda), 0), m_pair(int'(rra), 0), m_pair(26, 0), m_pair(28, 0), m_pair(30, 0),
              {8'h00, m_sreg_a}, {8'h00, m_sreg_b}};
      for (int p = 0; p < 12; p++) begin
        n_tests++;
        if (got[p] !== exp[p]) begin
          n_fail++;
          $display("FAIL random cycle %0d %s: got %h expected %h", i, nm[p], got[p], exp[p]);
        end
      end
      step();
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_midinit_reset();
    @(negedge clk);
    write_byte(5'd31, 8'hEE);
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (z_a[15:8] !== 8'hEE || z_b[15:8] !== 8'hEE) begin
      n_fail++;
      $display("FAIL r31 before reset: got %h/%h expected ee", z_a[15:8], z_b[15:8]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL run reset ready: got %b/%b expected 0", ready_a, ready_b);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
        n_fail++;
        $display("FAIL partial init ready edge %0d: got %b/%b expected 0", k, ready_a, ready_b);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (sreg_a !== SR_A || sreg_b !== SR_B || ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mid-init reset: got sreg %h/%h ready %b expected %h/%h 0", sreg_a, sreg_b, ready_a, SR_A, SR_B);
    end
    @(negedge clk);
    rst = 1'b0;
    run_init("midinit");
    @(negedge clk);
    rda = 5'd30;
    rra = 5'd31;
    #1;
    n_tests++;
    if (z_a !== 16'h0000 || z_b !== 16'h0000 || rr_a !== 16'h0000 || rr_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL r31 after reinit: got z %h/%h rr %h/%h expected 0", z_a, z_b, rr_a, rr_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    rda = 5'd0;
    rra = 5'd0;
    idle_inputs();
    m_reset();
    test_reset();
    test_directed();
    test_bypass();
    test_sreg();
    test_random();
    test_midinit_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
